i_cache_control: RTL and testbench

I_CACHE_CONTROL -- requirements
Module: i_cache_control

---
 rtl/i_cache_control_if.sv | 28 ++
 rtl/i_cache_control.sv | 51 +++++
 tb/tb_i_cache_control.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/i_cache_control_if.sv
// i_cache_control_if: CPU, datapath and physical-memory signals of the instruction-cache controller
interface i_cache_control_if;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_resp;
    logic        hit;
    logic        lru_out;
    logic        waydatamux_sel;
    logic        lru_write;
    logic        lru_data;
    logic        way0_write;
    logic        way1_write;
    logic        way0_valid_data;
    logic        way1_valid_data;
    logic        pmem_read;
    logic [15:0] pmem_address;
    logic        pmem_resp;
    modport master (
        output mem_read, mem_address, hit, lru_out, waydatamux_sel, pmem_resp,
        input  mem_resp, lru_write, lru_data, way0_write, way1_write,
               way0_valid_data, way1_valid_data, pmem_read, pmem_address
    );
    modport slave (
        input  mem_read, mem_address, hit, lru_out, waydatamux_sel, pmem_resp,
        output mem_resp, lru_write, lru_data, way0_write, way1_write,
               way0_valid_data, way1_valid_data, pmem_read, pmem_address
    );
endinterface

// File: rtl/i_cache_control.sv
// i_cache_control: two-state instruction-cache controller with saturating hit/miss statistics
module i_cache_control #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    i_cache_control_if.slave   bus,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);
    typedef enum logic {IDLE, FILL} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic idle, fill, hit_ev, miss_ev, fill_done;
    // decodes are gated by reset_n so every strobe is low while reset is held
    assign idle      = reset_n && state_q == IDLE;
    assign fill      = reset_n && state_q == FILL;
    assign hit_ev    = idle && bus.mem_read && bus.hit;
    assign miss_ev   = idle && bus.mem_read && !bus.hit;
    assign fill_done = fill && bus.pmem_resp;
    assign bus.mem_resp        = hit_ev;
    assign bus.lru_write       = hit_ev;
    assign bus.lru_data        = ~bus.waydatamux_sel;
    assign bus.pmem_read       = fill;
    assign bus.pmem_address    = {bus.mem_address[15:4], 4'b0000};
    assign bus.way0_write      = fill_done && !bus.lru_out;
    assign bus.way1_write      = fill_done && bus.lru_out;
    assign bus.way0_valid_data = bus.way0_write;
    assign bus.way1_valid_data = bus.way1_write;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    // next state and saturating counter updates; clear wins over increment
    always_comb begin
        state_d = miss_ev ? FILL : fill_done ? IDLE : state_q;
        hit_d   = clr_stats ? '0 : (hit_ev && !(&hit_q)) ? hit_q + CNT_W'(1) : hit_q;
        miss_d  = clr_stats ? '0 : (miss_ev && !(&miss_q)) ? miss_q + CNT_W'(1) : miss_q;
    end
    // state and statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end
endmodule

// File: tb/tb_i_cache_control.sv
// tb_i_cache_control: directed vector table plus multi-cycle miss/reset/saturation sequences
module tb_i_cache_control;
    logic clk = 1'b0;
    logic reset_n;
    logic clr_stats;
    logic [3:0] hit_count, miss_count;
    int n_chk = 0;
    int n_fail = 0;
    int exp_hit = 0;
    i_cache_control_if bif ();
    i_cache_control #(.CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif.slave),
        .clr_stats(clr_stats), .hit_count(hit_count), .miss_count(miss_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        string name;
        logic mr, hit, sel, lru;
        logic resp, lw, ld;
    } vec_t;
    vec_t vecs [5];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask
    task automatic drive(input logic mr, input logic h, input logic sel, input logic lru, input logic pr);
        bif.mem_read = mr;
        bif.hit = h;
        bif.waydatamux_sel = sel;
        bif.lru_out = lru;
        bif.pmem_resp = pr;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        vecs[0] = '{"idle_quiet", 0, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{"idle_hit_no_read", 0, 1, 1, 1, 0, 0, 0};
        vecs[2] = '{"hit_way1", 1, 1, 1, 0, 1, 1, 0};
        vecs[3] = '{"hit_way0", 1, 1, 0, 1, 1, 1, 1};
        vecs[4] = '{"idle_quiet_lru1", 0, 0, 1, 1, 0, 0, 0};
        bif.mem_address = 16'h1234;
        clr_stats = 1'b0;
        reset_n = 1'b0;
        drive(1, 1, 0, 0, 1);
        repeat (2) cyc();
        chk("rst_mem_resp", bif.mem_resp, 0);
        chk("rst_lru_write", bif.lru_write, 0);
        chk("rst_pmem_read", bif.pmem_read, 0);
        chk("rst_way_write", {bif.way0_write, bif.way1_write}, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].mr, vecs[i].hit, vecs[i].sel, vecs[i].lru, 0);
            @(negedge clk);
            chk({vecs[i].name, "_mem_resp"}, bif.mem_resp, vecs[i].resp);
            chk({vecs[i].name, "_lru_write"}, bif.lru_write, vecs[i].lw);
            if (vecs[i].lw) chk({vecs[i].name, "_lru_data"}, bif.lru_data, vecs[i].ld);
            chk({vecs[i].name, "_pmem_read"}, bif.pmem_read, 0);
            chk({vecs[i].name, "_way_write"}, {bif.way0_write, bif.way1_write}, 0);
            chk({vecs[i].name, "_pmem_addr"}, bif.pmem_address, 16'h1230);
            if (vecs[i].resp) exp_hit++;
            cyc();
            chk({vecs[i].name, "_hit_count"}, hit_count, exp_hit);
        end
        // miss with lru_out=1, fill response on the third FILL cycle
        drive(1, 0, 0, 1, 0);
        @(negedge clk);
        chk("miss_idle_resp", bif.mem_resp, 0);
        chk("miss_idle_pmem_read", bif.pmem_read, 0);
        cyc();
        chk("miss_count_1", miss_count, 1);
        for (int i = 0; i < 3; i++) begin
            bif.pmem_resp = (i == 2);
            @(negedge clk);
            chk("fill_pmem_read", bif.pmem_read, 1);
            chk("fill_pmem_addr", bif.pmem_address, 16'h1230);
            chk("fill_mem_resp", bif.mem_resp, 0);
            chk("fill_way_write", {bif.way0_write, bif.way1_write}, (i == 2) ? 2'b01 : 2'b00);
            chk("fill_valid_data", {bif.way0_valid_data, bif.way1_valid_data}, (i == 2) ? 2'b01 : 2'b00);
            cyc();
        end
        drive(1, 1, 1, 1, 0);
        @(negedge clk);
        chk("relookup_mem_resp", bif.mem_resp, 1);
        chk("relookup_pmem_read", bif.pmem_read, 0);
        cyc();
        exp_hit++;
        chk("relookup_hit_count", hit_count, exp_hit);
        chk("miss_count_still_1", miss_count, 1);
        // mem_read drops mid-fill, lru_out=0 victim
        drive(1, 0, 0, 0, 0);
        cyc();
        bif.mem_read = 1'b0;
        @(negedge clk);
        chk("abort_fill_pmem_read", bif.pmem_read, 1);
        chk("abort_fill_resp", bif.mem_resp, 0);
        cyc();
        bif.pmem_resp = 1'b1;
        @(negedge clk);
        chk("abort_way_write", {bif.way0_write, bif.way1_write}, 2'b10);
        chk("abort_valid_data", {bif.way0_valid_data, bif.way1_valid_data}, 2'b10);
        chk("abort_resp_cycle_resp", bif.mem_resp, 0);
        cyc();
        bif.pmem_resp = 1'b0;
        @(negedge clk);
        chk("abort_after_resp", bif.mem_resp, 0);
        chk("abort_after_pmem_read", bif.pmem_read, 0);
        chk("miss_count_2", miss_count, 2);
        // reset asserted during FILL
        drive(1, 0, 0, 1, 0);
        cyc();
        @(negedge clk);
        chk("rfill_pmem_read", bif.pmem_read, 1);
        #1;
        reset_n = 1'b0;
        bif.pmem_resp = 1'b1;
        #1;
        chk("rfill_pmem_read_drop", bif.pmem_read, 0);
        chk("rfill_no_write", {bif.way0_write, bif.way1_write}, 0);
        chk("rfill_hit_count", hit_count, 0);
        chk("rfill_miss_count", miss_count, 0);
        cyc();
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rfill_idle_pmem_read", bif.pmem_read, 0);
        cyc();
        // saturation and clear priority
        exp_hit = 0;
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("post_reset_hit_resp", bif.mem_resp, 1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp_hit = (exp_hit == 15) ? 15 : exp_hit + 1;
            chk("sat_hit_count", hit_count, exp_hit);
        end
        clr_stats = 1'b1;
        @(negedge clk);
        chk("clr_cycle_resp", bif.mem_resp, 1);
        cyc();
        chk("clr_hit_count", hit_count, 0);
        chk("clr_miss_count", miss_count, 0);
        clr_stats = 1'b0;
        cyc();
        chk("after_clr_hit_count", hit_count, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
